load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_align.sv | 48 ++++
 rtl/load_store_unit.sv | 159 +++++++++++++++
 tb/tb_load_store_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared types, access-size codes and defaults for the load/store unit.
// Revision : 1.0
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } lsu_state_t;

    // funct3[1:0] access size; funct3[2] selects zero-extension on loads
    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;
    localparam logic [1:0] c_SIZE_RSVD = 2'b11;

    localparam int c_TIMEOUT_CYCLES = 255;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            c_SIZE_BYTE: bad = 1'b0;
            c_SIZE_HALF: bad = addr_lo[0];
            c_SIZE_WORD: bad = |addr_lo;
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : Byte-lane logic: store strobes and lane replication, load extract/extend.
// Revision : 1.0
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
        w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];
        o_wstrb = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
        case (i_funct3[1:0])
            c_SIZE_BYTE: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = i_funct3[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            c_SIZE_HALF: begin
                o_wstrb = 4'b0011 << i_addr_lo;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = i_funct3[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            end
            default: begin
                o_wstrb = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rdata;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Single-outstanding RV32I load/store bridge from CPU to a valid/ready bus.
// Revision : 1.0
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_read_en,
    input  logic        req_write_en,
    input  logic [2:0]  req_funct3,
    output logic [31:0] rsp_rdata,
    output logic        stall,
    output logic        lsu_error,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int                 c_CNT_W   = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT_CYCLES);

    lsu_state_t         r_state;
    logic [c_CNT_W-1:0] r_count;
    logic [1:0]         r_addr_lo;
    logic [2:0]         r_funct3;
    logic [31:0]        r_rsp_rdata;
    logic               r_lsu_error;
    logic               r_bus_valid;
    logic               r_bus_we;
    logic [31:0]        r_bus_addr;
    logic [31:0]        r_bus_wdata;
    logic [3:0]         r_bus_wstrb;

    logic               w_any_req;
    logic               w_misaligned;
    logic               w_in_idle;
    logic [1:0]         w_lane_addr;
    logic [2:0]         w_lane_funct3;
    logic [3:0]         w_wstrb;
    logic [31:0]        w_wdata;
    logic [31:0]        w_rdata_ext;

    assign w_any_req    = req_read_en | req_write_en;
    assign w_misaligned = is_misaligned(req_funct3[1:0], req_addr[1:0]);
    assign w_in_idle    = (r_state == IDLE);

    // Store lanes come from the live request in IDLE; load extraction uses the captured access.
    assign w_lane_addr   = w_in_idle ? req_addr[1:0] : r_addr_lo;
    assign w_lane_funct3 = w_in_idle ? req_funct3    : r_funct3;

    lsu_align u_align (
        .i_addr_lo (w_lane_addr),
        .i_funct3  (w_lane_funct3),
        .i_wdata   (req_wdata),
        .i_rdata   (bus_rdata),
        .o_wstrb   (w_wstrb),
        .o_wdata   (w_wdata),
        .o_rdata   (w_rdata_ext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_addr_lo   <= '0;
            r_funct3    <= '0;
            r_rsp_rdata <= '0;
            r_lsu_error <= 1'b0;
            r_bus_valid <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wstrb <= '0;
        end else begin
            r_lsu_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_count <= '0;
                    if (w_any_req && w_misaligned) begin
                        r_lsu_error <= 1'b1;
                        r_rsp_rdata <= '0;
                    end else if (w_any_req) begin
                        r_state     <= REQ;
                        r_bus_valid <= 1'b1;
                        r_bus_we    <= req_write_en;
                        r_bus_addr  <= {req_addr[31:2], 2'b00};
                        r_bus_wdata <= w_wdata;
                        r_bus_wstrb <= req_write_en ? w_wstrb : 4'b0000;
                        r_addr_lo   <= req_addr[1:0];
                        r_funct3    <= req_funct3;
                    end
                end
                REQ: begin
                    if (bus_ready) begin
                        r_bus_valid <= 1'b0;
                        r_count     <= '0;
                        r_state     <= r_bus_we ? DONE : WAIT_RSP;
                    end else if (r_count == c_CNT_MAX) begin
                        r_bus_valid <= 1'b0;
                        r_lsu_error <= 1'b1;
                        r_rsp_rdata <= '1;
                        r_count     <= '0;
                        r_state     <= DONE;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                WAIT_RSP: begin
                    if (bus_rvalid) begin
                        r_rsp_rdata <= w_rdata_ext;
                        r_count     <= '0;
                        r_state     <= DONE;
                    end else if (r_count == c_CNT_MAX) begin
                        r_lsu_error <= 1'b1;
                        r_rsp_rdata <= '1;
                        r_count     <= '0;
                        r_state     <= DONE;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                // The request still on the inputs here is the one just completed; never reissue it.
                DONE: begin
                    r_count <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_count <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign stall     = rst & ((w_in_idle & w_any_req & ~w_misaligned) |
                              (r_state == REQ) | (r_state == WAIT_RSP));
    assign rsp_rdata = r_rsp_rdata;
    assign lsu_error = r_lsu_error;
    assign bus_valid = r_bus_valid;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_wstrb = r_bus_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Directed self-checking bench for load_store_unit.
// Revision : 1.0
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_read_en;
    logic        req_write_en;
    logic [2:0]  req_funct3;
    logic [31:0] rsp_rdata;
    logic        stall;
    logic        lsu_error;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int n_vec = 0;
    int n_err = 0;

    // Observations gathered by run_access
    int          res_stall;
    int          res_cycles;
    logic [31:0] res_addr;
    logic [31:0] res_wdata;
    logic [3:0]  res_strb;
    logic        res_we;
    logic        res_err;
    logic        res_valid;
    logic [31:0] res_rdata;

    load_store_unit #(.TIMEOUT_CYCLES(255)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_read_en  (req_read_en),
        .req_write_en (req_write_en),
        .req_funct3   (req_funct3),
        .rsp_rdata    (rsp_rdata),
        .stall        (stall),
        .lsu_error    (lsu_error),
        .bus_valid    (bus_valid),
        .bus_ready    (bus_ready),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_wstrb    (bus_wstrb),
        .bus_rvalid   (bus_rvalid),
        .bus_rdata    (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic clear_req();
        req_addr     = '0;
        req_wdata    = '0;
        req_read_en  = 1'b0;
        req_write_en = 1'b0;
        req_funct3   = '0;
    endtask

    // CPU + bus model: request held while stall is high, dropped after a low-stall cycle.
    // rdy_dly: bus_ready in the (rdy_dly+1)-th bus_valid cycle, -1 = never.
    // rv_dly : bus_rvalid in the (rv_dly+1)-th cycle after acceptance, -1 = never.
    task automatic run_access(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                              input logic we, input logic re, input int rdy_dly, input int rv_dly,
                              input logic [31:0] rd);
        int   vcnt;
        int   wcnt;
        logic accepted;
        logic done;
        logic last_stall;
        vcnt = 0; wcnt = 0; accepted = 1'b0; done = 1'b0; last_stall = 1'b1;
        res_stall = 0; res_cycles = 0; res_addr = '0; res_wdata = '0; res_strb = '0;
        res_we = 1'b0; res_err = 1'b0; res_valid = 1'b0; res_rdata = '0;
        req_addr = a; req_wdata = wd; req_funct3 = f3; req_write_en = we; req_read_en = re;
        for (int k = 0; k < 600 && !done; k++) begin
            bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
            if (bus_valid) begin
                res_valid = 1'b1; res_addr = bus_addr; res_wdata = bus_wdata;
                res_strb = bus_wstrb; res_we = bus_we;
                if (vcnt == rdy_dly) begin
                    bus_ready = 1'b1;
                    // Same-cycle read data must be discarded by the DUT.
                    if (!bus_we) begin
                        bus_rvalid = 1'b1;
                        bus_rdata  = 32'hBAD0_BAD0;
                    end
                end
                vcnt++;
            end else if (accepted) begin
                if (wcnt == rv_dly) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = rd;
                end
                wcnt++;
            end
            @(negedge clk);
            res_stall += int'(stall);
            res_err   |= lsu_error;
            last_stall = stall;
            if (bus_valid && bus_ready) accepted = 1'b1;
            if (k > 0 && !stall) begin
                done       = 1'b1;
                res_rdata  = rsp_rdata;
                res_cycles = k;
            end
            @(posedge clk);
            #1;
            if (!last_stall) clear_req();
        end
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        clear_req();
        if (!done) check("access_bound", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        clear_req();
        // A request present during reset must not raise stall.
        req_read_en = 1'b1; req_funct3 = 3'b010;
        repeat (2) @(negedge clk);
        check("rst_stall",     32'(stall),     32'd0);
        check("rst_bus_valid", 32'(bus_valid), 32'd0);
        check("rst_error",     32'(lsu_error), 32'd0);
        check("rst_rdata",     rsp_rdata,      32'd0);
        @(posedge clk); #1;
        clear_req();
        rst = 1'b1;
        @(posedge clk); #1;

        // SW 0x100
        run_access(32'h100, 32'hDEAD_BEEF, 3'b010, 1'b1, 1'b0, 1, -1, '0);
        check("sw_stall_cycles", 32'(res_stall), 32'd3);
        check("sw_done_cycle",   32'(res_cycles), 32'd3);
        check("sw_addr",  res_addr,        32'h0000_0100);
        check("sw_strb",  32'(res_strb),   32'h0000_000F);
        check("sw_wdata", res_wdata,       32'hDEAD_BEEF);
        check("sw_we",    32'(res_we),     32'd1);
        check("sw_err",   32'(res_err),    32'd0);

        // SB 0x103
        run_access(32'h103, 32'h0000_00A5, 3'b000, 1'b1, 1'b0, 0, -1, '0);
        check("sb_strb",  32'(res_strb), 32'h0000_0008);
        check("sb_wdata", res_wdata,     32'hA5A5_A5A5);
        check("sb_addr",  res_addr,      32'h0000_0100);

        // SH 0x102
        run_access(32'h102, 32'h1234_BEEF, 3'b001, 1'b1, 1'b0, 2, -1, '0);
        check("sh_strb",  32'(res_strb), 32'h0000_000C);
        check("sh_wdata", res_wdata,     32'hBEEF_BEEF);

        // Read and write together behave as a write
        run_access(32'h108, 32'hCAFE_F00D, 3'b010, 1'b1, 1'b1, 0, -1, '0);
        check("rw_we",   32'(res_we),   32'd1);
        check("rw_strb", 32'(res_strb), 32'h0000_000F);

        // LB / LBU 0x102
        run_access(32'h102, '0, 3'b000, 1'b0, 1'b1, 0, 2, 32'h0080_0000);
        check("lb_rdata", res_rdata,     32'hFFFF_FF80);
        check("lb_strb",  32'(res_strb), 32'd0);
        check("lb_we",    32'(res_we),   32'd0);
        run_access(32'h102, '0, 3'b100, 1'b0, 1'b1, 1, 0, 32'h0080_0000);
        check("lbu_rdata", res_rdata, 32'h0000_0080);

        // LH / LHU 0x102
        run_access(32'h102, '0, 3'b001, 1'b0, 1'b1, 0, 0, 32'h8001_0000);
        check("lh_rdata", res_rdata, 32'hFFFF_8001);
        run_access(32'h102, '0, 3'b101, 1'b0, 1'b1, 0, 1, 32'h8001_0000);
        check("lhu_rdata", res_rdata, 32'h0000_8001);

        // LW 0x104
        run_access(32'h104, '0, 3'b010, 1'b0, 1'b1, 1, 3, 32'h1234_5678);
        check("lw_rdata", res_rdata, 32'h1234_5678);
        check("lw_addr",  res_addr,  32'h0000_0104);
        check("lw_err",   32'(res_err), 32'd0);

        // Misaligned accesses
        run_access(32'h102, '0, 3'b010, 1'b0, 1'b1, 0, 0, 32'h1111_1111);
        check("mis_lw_valid", 32'(res_valid), 32'd0);
        check("mis_lw_stall", 32'(res_stall), 32'd0);
        check("mis_lw_err",   32'(res_err),   32'd1);
        check("mis_lw_rdata", res_rdata,      32'd0);
        run_access(32'h101, 32'h1234, 3'b001, 1'b1, 1'b0, 0, -1, '0);
        check("mis_sh_valid", 32'(res_valid), 32'd0);
        check("mis_sh_err",   32'(res_err),   32'd1);
        run_access(32'h100, '0, 3'b011, 1'b0, 1'b1, 0, 0, 32'h1111_1111);
        check("rsvd_err",   32'(res_err),   32'd1);
        check("rsvd_stall", 32'(res_stall), 32'd0);

        // Response timeout
        run_access(32'h200, '0, 3'b010, 1'b0, 1'b1, 0, -1, '0);
        check("to_rsp_err",   32'(res_err), 32'd1);
        check("to_rsp_rdata", res_rdata,    32'hFFFF_FFFF);
        check("to_rsp_len",   32'(res_stall >= 257 && res_stall <= 259), 32'd1);
        @(negedge clk);
        check("to_idle_stall", 32'(stall),     32'd0);
        check("to_idle_valid", 32'(bus_valid), 32'd0);
        @(posedge clk); #1;
        run_access(32'h204, '0, 3'b010, 1'b0, 1'b1, 0, 0, 32'h0BAD_F00D);
        check("after_to_rdata", res_rdata, 32'h0BAD_F00D);

        // Acceptance timeout
        run_access(32'h300, 32'h55, 3'b010, 1'b1, 1'b0, -1, -1, '0);
        check("to_req_err",   32'(res_err), 32'd1);
        check("to_req_rdata", res_rdata,    32'hFFFF_FFFF);
        @(negedge clk);
        check("to_req_valid", 32'(bus_valid), 32'd0);
        @(posedge clk); #1;

        // Reset while waiting for read data
        run_access(32'h104, '0, 3'b010, 1'b0, 1'b1, 0, 0, 32'h7777_7777);
        req_addr = 32'h110; req_funct3 = 3'b010; req_read_en = 1'b1;
        @(posedge clk); #1;
        bus_ready = 1'b1;
        @(posedge clk); #1;
        bus_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(bus_valid), 32'd0);
        check("mid_rst_stall", 32'(stall),     32'd0);
        check("mid_rst_rdata", rsp_rdata,      32'd0);
        @(posedge clk); #1;
        clear_req();
        rst = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = 32'h5555_5555;
        @(posedge clk); #1;
        bus_rvalid = 1'b0; bus_rdata = '0;
        @(negedge clk);
        check("late_rvalid_rdata", rsp_rdata,      32'd0);
        check("late_rvalid_stall", 32'(stall),     32'd0);
        check("late_rvalid_valid", 32'(bus_valid), 32'd0);
        check("late_rvalid_err",   32'(lsu_error), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
